// File: rtl/puf_ro_meas_if.sv
// Bus between the RO-PUF measurement controller and its environment.
// The environment issues the start and window and supplies the two raw
// ring-oscillator outputs. The controller returns the RO enables, status
// and the held measurement results.
//   slave  : controller side (puf_ro_meas)
//   master : host / oscillator side
interface puf_ro_meas_if #(
  parameter int CNT_W = 16,
  parameter int WIN_W = 16
);
  logic             i_start;
  logic [WIN_W-1:0] i_win;
  logic             i_ro_a;
  logic             i_ro_b;
  logic             o_en_a;
  logic             o_en_b;
  logic             o_busy;
  logic             o_done;
  logic             o_resp;
  logic             o_tie;
  logic [CNT_W-1:0] o_cnt_a;
  logic [CNT_W-1:0] o_cnt_b;

  modport slave (
    input  i_start, i_win, i_ro_a, i_ro_b,
    output o_en_a, o_en_b, o_busy, o_done, o_resp, o_tie, o_cnt_a, o_cnt_b
  );

  modport master (
    output i_start, i_win, i_ro_a, i_ro_b,
    input  o_en_a, o_en_b, o_busy, o_done, o_resp, o_tie, o_cnt_a, o_cnt_b
  );
endinterface

// File: rtl/puf_ro_meas.sv
// RO-PUF measurement controller.
// Enables a pair of ring oscillators, synchronises their outputs into i_clk,
// lets them settle, counts rising edges of each over a programmable window
// and reports one response bit (cnt_a > cnt_b) plus a tie flag.
// Ports:
//   i_clk  : system clock
//   i_rst  : synchronous active-high reset, clears all state and outputs
//   bus    : puf_ro_meas_if.slave
//            i_start/i_win      start a measurement / window in cycles (0 -> 1)
//            i_ro_a/i_ro_b      asynchronous RO outputs
//            o_en_a/o_en_b      RO enables (high in SETTLE and COUNT)
//            o_busy/o_done      busy outside IDLE / one-cycle result strobe
//            o_resp/o_tie       comparison result, held until replaced
//            o_cnt_a/o_cnt_b    saturating raw edge counts, held likewise
module puf_ro_meas #(
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input logic          i_clk,
  input logic          i_rst,
  puf_ro_meas_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

  localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

  state_t state, state_nxt;

  logic ro_a_p0, ro_a_p1, ro_a_p2;
  logic ro_b_p0, ro_b_p1, ro_b_p2;
  logic edge_a, edge_b;

  logic [SET_W-1:0] settle_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [CNT_W-1:0] cnt_a, cnt_b;
  logic [CNT_W-1:0] cnt_a_nxt, cnt_b_nxt;
  logic             count_last;

  logic             en_c, busy_c, done_c;
  logic             resp_q, tie_q;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    if (inc && (c != {CNT_W{1'b1}}))
      return c + CNT_W'(1);
    return c;
  endfunction

  // A zero window would never terminate the down-counter; run it as one.
  function automatic logic [WIN_W-1:0] win_min1(input logic [WIN_W-1:0] w);
    return (w == '0) ? WIN_W'(1) : w;
  endfunction

  // ---- stage p0/p1: two-flop synchroniser, p2: history for edge detect ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ro_a_p0 <= 1'b0;
      ro_a_p1 <= 1'b0;
      ro_a_p2 <= 1'b0;
      ro_b_p0 <= 1'b0;
      ro_b_p1 <= 1'b0;
      ro_b_p2 <= 1'b0;
    end else begin
      ro_a_p0 <= bus.i_ro_a;
      ro_a_p1 <= ro_a_p0;
      ro_a_p2 <= ro_a_p1;
      ro_b_p0 <= bus.i_ro_b;
      ro_b_p1 <= ro_b_p0;
      ro_b_p2 <= ro_b_p1;
    end
  end

  assign edge_a = ro_a_p1 & ~ro_a_p2;
  assign edge_b = ro_b_p1 & ~ro_b_p2;

  // Next counts include this cycle's edge so the last COUNT cycle is captured.
  assign cnt_a_nxt  = sat_inc(cnt_a, edge_a);
  assign cnt_b_nxt  = sat_inc(cnt_b, edge_b);
  assign count_last = (win_cnt == WIN_W'(1));

  // ---- control: state register ----
  always_ff @(posedge i_clk) begin
    if (i_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // ---- control: next state and state-decoded outputs ----
  always_comb begin
    state_nxt = state;
    en_c      = 1'b0;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start)
          state_nxt = SETTLE;
      end
      SETTLE: begin
        en_c   = 1'b1;
        busy_c = 1'b1;
        if (settle_cnt == SET_LAST)
          state_nxt = COUNT;
      end
      COUNT: begin
        en_c   = 1'b1;
        busy_c = 1'b1;
        if (count_last)
          state_nxt = DONE;
      end
      DONE: begin
        busy_c    = 1'b1;
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p3: counters, window and result registers ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      settle_cnt <= '0;
      win_cnt    <= '0;
      cnt_a      <= '0;
      cnt_b      <= '0;
      cnt_a_q    <= '0;
      cnt_b_q    <= '0;
      resp_q     <= 1'b0;
      tie_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            win_cnt    <= win_min1(bus.i_win);
            cnt_a      <= '0;
            cnt_b      <= '0;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + SET_W'(1);
        end
        COUNT: begin
          cnt_a   <= cnt_a_nxt;
          cnt_b   <= cnt_b_nxt;
          win_cnt <= win_cnt - WIN_W'(1);
          if (count_last) begin
            cnt_a_q <= cnt_a_nxt;
            cnt_b_q <= cnt_b_nxt;
            resp_q  <= (cnt_a_nxt > cnt_b_nxt);
            tie_q   <= (cnt_a_nxt == cnt_b_nxt);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.o_en_a  = en_c;
  assign bus.o_en_b  = en_c;
  assign bus.o_busy  = busy_c;
  assign bus.o_done  = done_c;
  assign bus.o_resp  = resp_q;
  assign bus.o_tie   = tie_q;
  assign bus.o_cnt_a = cnt_a_q;
  assign bus.o_cnt_b = cnt_b_q;

endmodule

// File: tb/tb_puf_ro_meas.sv
module tb_puf_ro_meas;

  localparam int SETTLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sq40 = 1'b0;
  logic sq50 = 1'b0;
  logic a_slow = 1'b0;
  logic b_slow = 1'b0;

  int tests = 0;
  int fails = 0;
  int lat;

  typedef struct {
    string tag;
    int    lat;
    int    a_lo, a_hi, b_lo, b_hi;
    bit    chk_rt;
    bit    resp, tie;
  } exp_t;

  exp_t sb[$];

  puf_ro_meas_if #(.CNT_W(16), .WIN_W(16)) m_if ();
  puf_ro_meas_if #(.CNT_W(4),  .WIN_W(16)) s_if ();

  puf_ro_meas #(.CNT_W(16), .WIN_W(16), .SETTLE_CYC(SETTLE)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (m_if.slave)
  );

  puf_ro_meas #(.CNT_W(4), .WIN_W(16), .SETTLE_CYC(SETTLE)) u_sat (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (s_if.slave)
  );

  always #5 clk = ~clk;

  // Free-running 40 ns / 50 ns oscillator waveforms, offset from clock edges.
  initial begin
    #3;
    forever #20 sq40 = ~sq40;
  end
  initial begin
    #3;
    forever #25 sq50 = ~sq50;
  end

  // RO models only oscillate while enabled.
  assign m_if.i_ro_a = m_if.o_en_a & (a_slow ? sq50 : sq40);
  assign m_if.i_ro_b = m_if.o_en_b & (b_slow ? sq50 : sq40);
  assign s_if.i_ro_a = s_if.o_en_a & sq40;
  assign s_if.i_ro_b = s_if.o_en_b & sq40;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input int win,
                              input int a_lo, input int a_hi,
                              input int b_lo, input int b_hi,
                              input bit chk_rt, input bit resp, input bit tie);
    exp_t e;
    e.tag    = tag;
    e.lat    = SETTLE + ((win == 0) ? 1 : win) + 1;
    e.a_lo   = a_lo;
    e.a_hi   = a_hi;
    e.b_lo   = b_lo;
    e.b_hi   = b_hi;
    e.chk_rt = chk_rt;
    e.resp   = resp;
    e.tie    = tie;
    return e;
  endfunction

  // One measurement on the main DUT; expectation is queued at start and
  // retired when o_done appears. With poke set, extra starts are issued in
  // COUNT and in DONE and must be ignored.
  task automatic measure(input int win, input exp_t e, input bit poke);
    exp_t ex;
    sb.push_back(e);
    m_if.i_win   = 16'(win);
    m_if.i_start = 1'b1;
    @(posedge clk); #1;
    m_if.i_start = 1'b0;
    lat = 1;
    chk({e.tag, "_en_settle"}, 32'(m_if.o_en_a & m_if.o_en_b & m_if.o_busy), 32'd1);
    while (!m_if.o_done && lat < 400) begin
      if (lat == 3) m_if.i_win = 16'd0;
      m_if.i_start = (poke && lat == 10) ? 1'b1 : 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    m_if.i_start = 1'b0;
    chk({e.tag, "_done_seen"}, 32'(m_if.o_done), 32'd1);
    ex = sb.pop_front();
    chk({ex.tag, "_latency"}, lat, ex.lat);
    chk({ex.tag, "_en_done"}, 32'(m_if.o_en_a | m_if.o_en_b), 32'd0);
    chk({ex.tag, "_cnt_a_rng"},
        32'((int'(m_if.o_cnt_a) >= ex.a_lo) && (int'(m_if.o_cnt_a) <= ex.a_hi)), 32'd1);
    chk({ex.tag, "_cnt_b_rng"},
        32'((int'(m_if.o_cnt_b) >= ex.b_lo) && (int'(m_if.o_cnt_b) <= ex.b_hi)), 32'd1);
    if (ex.chk_rt) begin
      chk({ex.tag, "_resp"}, 32'(m_if.o_resp), 32'(ex.resp));
      chk({ex.tag, "_tie"},  32'(m_if.o_tie),  32'(ex.tie));
    end
    if (poke) begin
      m_if.i_start = 1'b1;
      @(posedge clk); #1;
      m_if.i_start = 1'b0;
      chk({ex.tag, "_idle_after_done"}, 32'(m_if.o_busy | m_if.o_done), 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk({ex.tag, "_no_second_meas"}, 32'(m_if.o_busy | m_if.o_en_a), 32'd0);
      chk({ex.tag, "_resp_held"}, 32'(m_if.o_resp), 32'(ex.resp));
      chk({ex.tag, "_tie_held"},  32'(m_if.o_tie),  32'(ex.tie));
    end else begin
      repeat (4) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit seen;
    m_if.i_start = 1'b0;
    m_if.i_win   = 16'd0;
    s_if.i_start = 1'b0;
    s_if.i_win   = 16'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctrl", 32'({m_if.o_en_a, m_if.o_en_b, m_if.o_busy, m_if.o_done}), 32'd0);
    chk("rst_res",  32'({m_if.o_resp, m_if.o_tie, m_if.o_cnt_a, m_if.o_cnt_b}), 32'd0);
    chk("rst_sat",  32'({s_if.o_busy, s_if.o_done, s_if.o_cnt_a, s_if.o_cnt_b}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // A faster than B
    a_slow = 1'b0; b_slow = 1'b1;
    measure(100, mk("a_fast", 100, 24, 26, 19, 21, 1'b1, 1'b1, 1'b0), 1'b0);

    // B faster than A
    a_slow = 1'b1; b_slow = 1'b0;
    measure(100, mk("b_fast", 100, 19, 21, 24, 26, 1'b1, 1'b0, 1'b0), 1'b0);

    // Identical in-phase ROs
    a_slow = 1'b0; b_slow = 1'b0;
    measure(100, mk("same", 100, 24, 26, 24, 26, 1'b1, 1'b0, 1'b1), 1'b0);
    chk("same_eq", 32'(m_if.o_cnt_a == m_if.o_cnt_b), 32'd1);

    // Zero window runs as one cycle
    measure(0, mk("win0", 0, 0, 1, 0, 1, 1'b0, 1'b0, 1'b0), 1'b0);

    // Starts during COUNT and DONE are ignored
    a_slow = 1'b0; b_slow = 1'b1;
    measure(40, mk("poke", 40, 9, 11, 7, 9, 1'b1, 1'b1, 1'b0), 1'b1);

    // Saturation on the 4-bit instance
    s_if.i_win   = 16'd100;
    s_if.i_start = 1'b1;
    @(posedge clk); #1;
    s_if.i_start = 1'b0;
    lat = 1;
    while (!s_if.o_done && lat < 400) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("sat_done_seen", 32'(s_if.o_done), 32'd1);
    chk("sat_latency", lat, 105);
    chk("sat_cnt_a", 32'(s_if.o_cnt_a), 32'd15);
    chk("sat_cnt_b", 32'(s_if.o_cnt_b), 32'd15);
    chk("sat_tie",  32'(s_if.o_tie),  32'd1);
    chk("sat_resp", 32'(s_if.o_resp), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset in the middle of COUNT
    m_if.i_win   = 16'd100;
    m_if.i_start = 1'b1;
    @(posedge clk); #1;
    m_if.i_start = 1'b0;
    lat = 1;
    while (lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rst_mid_en_before", 32'(m_if.o_en_a), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_ctrl", 32'({m_if.o_en_a, m_if.o_en_b, m_if.o_busy, m_if.o_done}), 32'd0);
    chk("rst_mid_res",  32'({m_if.o_resp, m_if.o_tie, m_if.o_cnt_a, m_if.o_cnt_b}), 32'd0);
    seen = 1'b0;
    repeat (150) begin
      @(posedge clk); #1;
      if (m_if.o_done || m_if.o_busy) seen = 1'b1;
    end
    chk("rst_mid_no_done", 32'(seen), 32'd0);

    // Normal measurement after the aborted one
    measure(100, mk("after_rst", 100, 24, 26, 19, 21, 1'b1, 1'b1, 1'b0), 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/puf_ro_meas.md
# puf_ro_meas

Measurement controller that sits on the output side of a pair of `puf_ro` ring oscillators. It enables both oscillators and synchronises their free-running `o_ro` outputs into the system clock domain. It then counts rising edges over a programmable window and produces one PUF response bit from comparing the two counts. It is the digital consumer of the `i_en`/`o_ro` interface and the building block for the RO-PUF challenge/response path.

## Interface
Parameters:
- `CNT_W`, 16: width of each edge counter and of `o_cnt_a`/`o_cnt_b`.
- `WIN_W`, 16: width of the window-length input `i_win`.
- `SETTLE_CYC`, 4: clock cycles the ROs run after enable before counting starts; minimum 1.

Ports:
- `i_clk`, in, 1: system clock. One clock domain only.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `i_start`, in, 1: starts a measurement. Sampled only in IDLE.
- `i_win`, in, WIN_W: counting window in `i_clk` cycles. Latched on an accepted start. 0 is treated as 1.
- `i_ro_a`, in, 1: asynchronous output of RO A.
- `i_ro_b`, in, 1: asynchronous output of RO B.
- `o_en_a`, out, 1: drives `i_en` of RO A.
- `o_en_b`, out, 1: drives `i_en` of RO B.
- `o_busy`, out, 1: high in SETTLE, COUNT and DONE.
- `o_done`, out, 1: one-cycle pulse when the result is valid.
- `o_resp`, out, 1: response bit, 1 if cnt_a > cnt_b. Held until the next accepted start.
- `o_tie`, out, 1: 1 if cnt_a == cnt_b. Held like `o_resp`.
- `o_cnt_a`, out, CNT_W: raw edge count of RO A. Held like `o_resp`.
- `o_cnt_b`, out, CNT_W: raw edge count of RO B. Held like `o_resp`.

## Operation
- **Synchroniser.** Each RO input passes through a 2-flop synchroniser, then a history flop.
  - Edge pulse = sync & ~hist.
  - Sync and history flops update every cycle and reset to 0.
  - Correct counting requires RO frequency < f_clk/2. Faster ROs alias; this is not detected.
- **IDLE.**
  - `o_en_*`=0, `o_busy`=0.
  - On `i_start`=1: latch `max(i_win,1)` into the window register, clear both counters, clear the settle counter, and go to SETTLE.
- **SETTLE.**
  - `o_en_*`=1.
  - Edge pulses are ignored.
  - Stays SETTLE_CYC cycles, then goes to COUNT.
- **COUNT.**
  - `o_en_*`=1.
  - Each edge pulse increments its counter.
  - Counters saturate at 2^CNT_W−1 and never wrap.
  - A down-counter loaded with the window length ends COUNT after exactly that many cycles.
  - An edge detected in the last COUNT cycle is counted.
- **DONE.**
  - `o_en_*`=0.
  - `o_done`=1 for this single cycle.
  - `o_cnt_a`/`o_cnt_b`, `o_resp` and `o_tie` are registered at the entry to DONE.
  - `o_resp`=0 whenever `o_tie`=1.
  - Unconditionally returns to IDLE next cycle.
- `i_start` outside IDLE is ignored. It is neither queued nor an error.
- `i_win` changes after an accepted start have no effect on the current measurement.

## Timing
- **Reset.**
  - On `i_rst`=1 at a clock edge, every output goes to 0 and state goes to IDLE. This includes `o_cnt_*`, `o_resp`, `o_tie`, `o_en_*`, `o_busy` and `o_done`.
  - Internal counters, the window register and the synchroniser flops also go to 0.
  - Reset mid-measurement aborts it: enables drop on that edge, no `o_done` is issued, and held results are cleared.
- **Cycle numbering.** Let cycle S be the cycle with `i_start`=1 sampled in IDLE, and W the effective window.
  - Cycles S+1 … S+SETTLE_CYC: SETTLE. `o_en_*`=1 and `o_busy`=1 from S+1.
  - Cycles S+SETTLE_CYC+1 … S+SETTLE_CYC+W: COUNT.
  - Cycle S+SETTLE_CYC+W+1: DONE. `o_done`=1, results valid, `o_en_*`=0.
  - Cycle S+SETTLE_CYC+W+2: IDLE, `o_busy`=0. The earliest next accepted start is this cycle.
- **Latency.** Start to `o_done` = SETTLE_CYC + W + 1 cycles.
- **Synchroniser delay.** The synchroniser adds 2–3 cycles of latency to edges. Counts may therefore differ by ±1 from the ideal `W·T_clk/T_ro`.

## Test plan
Conditions for all cases: `i_clk` 10 ns, SETTLE_CYC=4, RO models run only while enabled.

- **A faster than B.**
  - Stimulus: RO A period 40 ns, RO B period 50 ns, `i_win`=100.
  - Required: `o_done` exactly 105 cycles after S; `o_cnt_a` 25±1, `o_cnt_b` 20±1, `o_resp`=1, `o_tie`=0; enables low in DONE.
- **B faster than A.**
  - Stimulus: periods swapped, `i_win`=100.
  - Required: `o_cnt_a` 20±1, `o_cnt_b` 25±1, `o_resp`=0, `o_tie`=0.
- **Identical ROs.**
  - Stimulus: identical in-phase 40 ns waveforms on both inputs.
  - Required: `o_cnt_a`==`o_cnt_b`, `o_tie`=1, `o_resp`=0.
- **Saturation.**
  - Stimulus: CNT_W=4, RO period 40 ns, `i_win`=100.
  - Required: both counts 15, `o_tie`=1, no wrap to small values.
- **Window edge cases and ignored starts.**
  - `i_win`=0 must behave as W=1, giving `o_done` at S+6.
  - `i_start` pulsed during COUNT and DONE must produce no second measurement; results stay held.
- **Reset mid-COUNT.**
  - Stimulus: `i_rst` pulsed at cycle S+50.
  - Required: on the next edge all outputs are 0; no `o_done` follows; a new start afterwards completes normally.
